// File: rtl/word_serializer.sv
// word_serializer: parallel-in, serial-out unloader. Accepts a WIDTH-bit word on an
// accepted load strobe and shifts it out MSB-first, one bit per enabled clock, with
// complementary outputs. All outputs come straight from flops.
// Optional feature macro: SERIALIZER_PARITY_EN appends an even-parity bit after the LSB.
module word_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             c,
  input  logic             r,
  input  logic             l,
  input  logic [WIDTH-1:0] d,
  input  logic             e,
  output logic             ld_ready,
  output logic             q,
  output logic             qn,
  output logic             q_valid,
  output logic             last,
  output logic             done
);

`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LastIdx = CW'(FRAME - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [FRAME-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FRAME-1:0] load_word;

  logic q_q, q_d;
  logic qn_q, qn_d;
  logic q_valid_q, q_valid_d;
  logic last_q, last_d;
  logic done_q, done_d;
  logic ld_ready_q, ld_ready_d;

  // Word as it will be shifted: data MSB first, parity (if enabled) in the final slot.
`ifdef SERIALIZER_PARITY_EN
  assign load_word = {d, ^d};
`else
  assign load_word = d;
`endif

  // Next-state logic for the frame FSM, shift register and bit counter.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (l) begin
          sr_d    = load_word;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // l is ignored here; e=0 holds everything so q stays stable.
        if (e) begin
          sr_d  = {sr_q[FRAME-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LastIdx) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // A load here wins over e, giving back-to-back frames.
        if (l) begin
          sr_d    = load_word;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without extra latency.
  always_comb begin
    q_valid_d  = (state_d == StShift);
    q_d        = q_valid_d & sr_d[FRAME-1];
    qn_d       = ~q_d;
    last_d     = q_valid_d && (cnt_d == LastIdx);
    done_d     = (state_d == StDone);
    ld_ready_d = (state_d != StShift);
  end

  // State and output registers; asynchronous reset aborts any frame in progress.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      q_q        <= 1'b0;
      qn_q       <= 1'b1;
      q_valid_q  <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      qn_q       <= qn_d;
      q_valid_q  <= q_valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      ld_ready_q <= ld_ready_d;
    end
  end

  assign q        = q_q;
  assign qn       = qn_q;
  assign q_valid  = q_valid_q;
  assign last     = last_q;
  assign done     = done_q;
  assign ld_ready = ld_ready_q;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: expected serial bits are queued when a load is
// driven and compared by a negedge monitor as the consumer takes them.
module tb_word_serializer;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FRAME = W;
  localparam bit PAR = 1'b0;
`endif

  logic         c, r, l, e;
  logic [W-1:0] d;
  logic         ld_ready, q, qn, q_valid, last, done;

  word_serializer #(.WIDTH(W)) dut (
    .c        (c),
    .r        (r),
    .l        (l),
    .d        (d),
    .e        (e),
    .ld_ready (ld_ready),
    .q        (q),
    .qn       (qn),
    .q_valid  (q_valid),
    .last     (last),
    .done     (done)
  );

  always #5 c = ~c;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard entries: {expected q, expected last}.
  logic [1:0] sb[$];
  int         done_cycs[$];
  int         cyc      = 0;
  int         done_cnt = 0;
  int         load_cyc = 0;
  logic       exp_done = 1'b0;
  logic       mon_inv_q, mon_inv_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare the presented bit against the scoreboard head; pop when consumed.
  always @(negedge c) begin
    logic [1:0] item;
    cyc++;
    if (!r) begin
      mon_inv_q = ~q;
      mon_inv_v = ~q_valid;
      check("qn_inv", {31'b0, qn}, {31'b0, mon_inv_q});
      check("ld_ready", {31'b0, ld_ready}, {31'b0, mon_inv_v});
      check("done", {31'b0, done}, {31'b0, exp_done});
      exp_done = 1'b0;
      if (done) begin
        done_cnt++;
        done_cycs.push_back(cyc);
      end
      if (q_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'b0, q_valid}, 32'd0);
        end else begin
          item = sb[0];
          check("q", {31'b0, q}, {31'b0, item[1]});
          check("last", {31'b0, last}, {31'b0, item[0]});
          if (e) begin
            void'(sb.pop_front());
            if (item[0]) exp_done = 1'b1;
          end
        end
      end else begin
        check("q_idle", {31'b0, q}, 32'd0);
        check("last_idle", {31'b0, last}, 32'd0);
      end
    end
  end

  // Wait for ld_ready, present one word for one edge, and queue its expected bits.
  task automatic load_word(input logic [W-1:0] w);
    int waited = 0;
    while (!ld_ready && waited < 50) begin
      @(posedge c);
      #1;
      waited++;
    end
    if (!ld_ready) begin
      check("load_timeout", {31'b0, ld_ready}, 32'd1);
      return;
    end
    l = 1'b1;
    d = w;
    for (int i = W - 1; i >= 0; i--) sb.push_back({w[i], (!PAR && i == 0)});
    if (PAR) sb.push_back({^w, 1'b1});
    @(posedge c);
    #1;
    l = 1'b0;
    load_cyc = cyc;
    check("lat_valid", {31'b0, q_valid}, 32'd1);
    check("lat_msb", {31'b0, q}, {31'b0, w[W-1]});
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 100) begin
      @(posedge c);
      n++;
    end
    check("done_timeout", done_cnt >= target ? 32'd1 : 32'd0, 32'd1);
    @(posedge c);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_q"}, {31'b0, q}, 32'd0);
    check({tag, "_qn"}, {31'b0, qn}, 32'd1);
    check({tag, "_valid"}, {31'b0, q_valid}, 32'd0);
    check({tag, "_last"}, {31'b0, last}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_ldrdy"}, {31'b0, ld_ready}, 32'd1);
  endtask

  initial begin
    int lc, n0;
    c = 1'b0; r = 1'b0; l = 1'b0; e = 1'b0; d = '0;
    #2;
    r = 1'b1;
    #1;
    check_reset_vals("rst_init");
    repeat (2) @(posedge c);
    #1;
    r = 1'b0;
    e = 1'b1;

    // Continuous shift of A5, with load-to-done latency.
    load_word(8'hA5);
    lc = load_cyc;
    wait_done(1);
    check("done_latency", done_cycs[$] - lc, FRAME + 1);

    // Stall three cycles while the second bit is presented.
    load_word(8'hF0);
    @(posedge c);
    #1;
    e = 1'b0;
    repeat (3) @(posedge c);
    #1;
    e = 1'b1;
    wait_done(2);

    // Mid-frame load attempt must be ignored.
    load_word(8'h3C);
    @(posedge c);
    #1;
    l = 1'b1;
    d = 8'hFF;
    check("ign_ldrdy0", {31'b0, ld_ready}, 32'd0);
    @(posedge c);
    #1;
    l = 1'b0;
    check("ign_ldrdy1", {31'b0, ld_ready}, 32'd0);
    wait_done(3);

    // Back-to-back frames: second load lands in the DONE cycle while e=1.
    n0 = done_cnt;
    load_word(8'h81);
    load_word(8'h7E);
    wait_done(n0 + 2);
    check("b2b_period", done_cycs[$] - done_cycs[$-1], FRAME + 1);

    // Parity word (plain 8-bit frame in the default build).
    load_word(8'h07);
    wait_done(n0 + 3);

    // Abort on the 4th bit of FF.
    n0 = done_cnt;
    load_word(8'hFF);
    repeat (3) begin
      @(posedge c);
      #1;
    end
    #2;
    r = 1'b1;
    sb.delete();
    exp_done = 1'b0;
    #1;
    check_reset_vals("rst_abort");
    repeat (2) @(posedge c);
    #1;
    check_reset_vals("rst_hold");
    r = 1'b0;
    repeat (12) @(posedge c);
    #1;
    check("abort_no_done", done_cnt, n0);
    check("abort_idle", {31'b0, q_valid}, 32'd0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-in, serial-out reader for the bit-register bank: accepts a WIDTH-bit word on a load strobe and shifts it out MSB-first, one bit per enabled clock, with complementary outputs. It is the unload side of the storage path. Words captured by the load-controlled bit registers are drained bit-serially to a downstream consumer, which paces the transfer with a shift-enable.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..32.
- c  input  1  clock; all state updates on the rising edge.
- r  input  1  reset; asynchronous, active-high.
- l  input  1  load strobe; a word is accepted when l=1 and ld_ready=1 at a rising edge.
- d  input  WIDTH  parallel word, sampled only on an accepted load.
- e  input  1  shift enable from the consumer; the current bit is consumed and the next presented when e=1 at a rising edge.
- ld_ready  output  1  block can accept a load this cycle.
- q  output  1  current serial bit.
- qn  output  1  always the inverse of q, including during reset.
- q_valid  output  1  q holds a frame bit.
- last  output  1  q holds the final bit of the frame.
- done  output  1  one-cycle pulse after the final bit is consumed.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ld_ready=1, q_valid=0, q=0.
  - On an accepted load: latch d into the shift register, clear the bit counter, go to SHIFT.
- SHIFT:
  - q = shift_reg[MSB], q_valid=1, ld_ready=0.
  - e=1: shift left by one (zero fill) and increment the counter.
  - e=0: hold all state, so q is stable.
  - last=1 when counter = FRAME-1.
  - e=1 while last=1: go to DONE.
- DONE:
  - done=1, q_valid=0, last=0, ld_ready=1, for exactly one cycle.
  - Accepted load: go directly to SHIFT (back-to-back frames).
  - No load: go to IDLE.
- FRAME = WIDTH, or WIDTH+1 with the parity feature (see Configuration).
- Counter width is ceil(log2(WIDTH+2)). The counter never wraps within a frame.
- l while ld_ready=0 (mid-frame) is ignored. d is not resampled and the frame continues unchanged.
- e while q_valid=0 is ignored.
- Reset asserted mid-frame aborts the frame immediately: no done pulse, and the partial word is discarded.

## Timing
- Reset values (asynchronous, while r=1): state=IDLE, q=0, qn=1, q_valid=0, last=0, done=0, ld_ready=1, shift register and counter cleared.
- Load-to-first-bit latency: 1 cycle. The load is accepted at edge N, and q_valid=1 with q=d[WIDTH-1] after edge N.
- With e held at 1, bit k appears after edge N+k. The final bit appears after edge N+FRAME-1, and done is high after edge N+FRAME.
- Minimum frame period with continuous e and a load during DONE: FRAME+1 cycles.
- All outputs are registered. There is no combinational path from l, d or e to any output.
- Simultaneous events:
  - Load in DONE together with e=1: e is ignored and the load proceeds.
  - r overrides every other input.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - An even-parity bit (XOR of all WIDTH data bits) is appended after the LSB, so FRAME=WIDTH+1.
  - Parity is computed at load time from d.
  - last marks the parity bit.
- SERIALIZER_PARITY_EN undefined:
  - FRAME=WIDTH, and last marks the data LSB.
  - No parity logic is present.

## Test plan
- Reset: assert r=1 mid-simulation with no clock edge -> q=0, qn=1, q_valid=0, done=0, ld_ready=1 immediately.
- WIDTH=8, load d=8'hA5, e=1 continuous -> q sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles. last=1 only on the 8th bit, done=1 on the next cycle, qn always equals ~q.
- Stall: load 8'hF0, e=0 for 3 cycles after the 2nd bit -> q stays 1 and the counter is held. Resuming gives the remaining 1,1,0,0,0,0, then done.
- Ignored load: during a frame of 8'h3C, pulse l with d=8'hFF -> output is still 0,0,1,1,1,1,0,0 and ld_ready stays 0 until DONE.
- Back-to-back: load 8'h81, then a load of 8'h7E in the DONE cycle -> 16 data bits total, done pulses twice, one idle cycle between frames (the DONE cycle).
- Abort and parity: assert r at the 4th bit of 8'hFF -> no done pulse and all outputs are at reset values. With SERIALIZER_PARITY_EN, load 8'h07 -> a 9th bit of 1 appears with last=1.
